muldiv_sched: RTL and testbench

- Issue scheduler and sequencer for the shared iterative multiply/divide unit behind the execute stage.
- Accepts one M-extension op per issue from the ID/EX boundary and pulses the unit's start strobe.
- Counts the unit's fixed latency, holds the result-valid until writeback accepts it, and cancels work on flush/trap.
- Drives the ready signal that decode uses to stall (mul_inst/div_inst && !ready), plus the in-flight rd tag for hazard compare.

---
 rtl/muldiv_sched.sv | 179 +++++++++++++++++
 tb/tb_muldiv_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sched.sv
// Issue scheduler for the shared iterative multiply/divide unit: launches one
// op at a time, counts its fixed latency, holds the result until writeback.
module muldiv_sched #(
  parameter int XLEN       = 32,
  parameter int MUL_CYCLES = 4,
  parameter int DIV_CYCLES = 33,
  parameter int CNT_W      = $clog2(DIV_CYCLES + 1)
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       stall_in,
  input  logic       flush,
  input  logic       issue_valid,
  input  logic       issue_is_div,
  input  logic [2:0] issue_sel,
  input  logic [4:0] issue_rd,
  input  logic       issue_div_zero,
  input  logic       wb_accept,
  output logic       mul_start,
  output logic       div_start,
  output logic [2:0] unit_sel,
  output logic       unit_ready,
  output logic       res_valid,
  output logic       res_is_div,
  output logic       res_dz,
  output logic       busy_valid,
  output logic [4:0] busy_rd,
  output logic       kill
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  if (XLEN < 1 || MUL_CYCLES < 1 || DIV_CYCLES < 1 ||
      MUL_CYCLES > (1 << CNT_W) || DIV_CYCLES > (1 << CNT_W)) begin : g_param_check
    $error("muldiv_sched: latency parameters do not fit CNT_W");
  end

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       sel_q, sel_d;
  logic [4:0]       rd_q, rd_d;
  logic             is_div_q, is_div_d;
  logic             dz_q, dz_d;
  logic             res_valid_q, res_valid_d;
  logic             mul_start_q, mul_start_d;
  logic             div_start_q, div_start_d;
  logic             kill_q, kill_d;
  logic             accept_s;
  logic             unit_ready_s;
  logic             issue_ok_s;

  // Accept only counts once the result is actually presented on res_valid.
  assign accept_s     = (state_q == S_DONE) & res_valid_q & wb_accept;
  assign unit_ready_s = (state_q == S_IDLE) | accept_s;
  assign issue_ok_s   = issue_valid & unit_ready_s & ~stall_in & ~flush;

  // Next-state logic: flush first, then a new launch, then per-state progress.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    rd_d        = rd_q;
    is_div_d    = is_div_q;
    dz_d        = dz_q;
    res_valid_d = res_valid_q;
    mul_start_d = 1'b0;
    div_start_d = 1'b0;
    kill_d      = 1'b0;
    if (flush) begin
      kill_d      = (state_q == S_MUL) | (state_q == S_DIV);
      state_d     = S_IDLE;
      cnt_d       = '0;
      sel_d       = 3'd0;
      rd_d        = 5'd0;
      is_div_d    = 1'b0;
      dz_d        = 1'b0;
      res_valid_d = 1'b0;
    end else if (issue_ok_s) begin
      sel_d       = issue_sel;
      rd_d        = issue_rd;
      is_div_d    = issue_is_div;
      dz_d        = 1'b0;
      res_valid_d = 1'b0;
      if (!issue_is_div) begin
        state_d     = S_MUL;
        cnt_d       = MUL_LAST;
        mul_start_d = 1'b1;
      end else if (issue_div_zero) begin
        // Shortcut result; from DONE this leaves a one-cycle res_valid gap.
        state_d     = S_DONE;
        cnt_d       = '0;
        dz_d        = 1'b1;
        res_valid_d = (state_q == S_IDLE);
      end else begin
        state_d     = S_DIV;
        cnt_d       = DIV_LAST;
        div_start_d = 1'b1;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_IDLE;
        end
        S_MUL, S_DIV: begin
          if (cnt_q == '0) begin
            state_d     = S_DONE;
            res_valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        S_DONE: begin
          if (!res_valid_q) begin
            res_valid_d = 1'b1;
          end else if (accept_s) begin
            state_d     = S_IDLE;
            sel_d       = 3'd0;
            rd_d        = 5'd0;
            is_div_d    = 1'b0;
            dz_d        = 1'b0;
            res_valid_d = 1'b0;
          end else begin
            res_valid_d = 1'b1;
          end
        end
        default: begin
          state_d     = S_IDLE;
          cnt_d       = '0;
          res_valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      sel_q       <= 3'd0;
      rd_q        <= 5'd0;
      is_div_q    <= 1'b0;
      dz_q        <= 1'b0;
      res_valid_q <= 1'b0;
      mul_start_q <= 1'b0;
      div_start_q <= 1'b0;
      kill_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      rd_q        <= rd_d;
      is_div_q    <= is_div_d;
      dz_q        <= dz_d;
      res_valid_q <= res_valid_d;
      mul_start_q <= mul_start_d;
      div_start_q <= div_start_d;
      kill_q      <= kill_d;
    end
  end

  assign mul_start  = mul_start_q;
  assign div_start  = div_start_q;
  assign unit_sel   = sel_q;
  assign unit_ready = unit_ready_s;
  assign res_valid  = res_valid_q;
  assign res_is_div = is_div_q;
  assign res_dz     = dz_q;
  assign busy_valid = (state_q != S_IDLE);
  assign busy_rd    = rd_q;
  assign kill       = kill_q;

endmodule

// File: tb/tb_muldiv_sched.sv
// Directed self-checking bench for muldiv_sched with hand-computed timing.
module tb_muldiv_sched;

  logic       clk = 1'b0;
  logic       Rst;
  logic       stall_in, flush, issue_valid, issue_is_div, issue_div_zero, wb_accept;
  logic [2:0] issue_sel;
  logic [4:0] issue_rd;
  logic       mul_start, div_start, unit_ready, res_valid, res_is_div, res_dz;
  logic       busy_valid, kill;
  logic [2:0] unit_sel;
  logic [4:0] busy_rd;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_sched #(.XLEN(32), .MUL_CYCLES(4), .DIV_CYCLES(33)) dut (
    .clk(clk), .Rst(Rst), .stall_in(stall_in), .flush(flush),
    .issue_valid(issue_valid), .issue_is_div(issue_is_div), .issue_sel(issue_sel),
    .issue_rd(issue_rd), .issue_div_zero(issue_div_zero), .wb_accept(wb_accept),
    .mul_start(mul_start), .div_start(div_start), .unit_sel(unit_sel),
    .unit_ready(unit_ready), .res_valid(res_valid), .res_is_div(res_is_div),
    .res_dz(res_dz), .busy_valid(busy_valid), .busy_rd(busy_rd), .kill(kill)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Flags packed as {mul_start, div_start, unit_ready, res_valid, busy_valid, kill}.
  task automatic expect_st(input string tag, input logic [5:0] flags, input logic [4:0] brd);
    chk({tag, "_flags"}, {26'd0, mul_start, div_start, unit_ready, res_valid, busy_valid, kill},
        {26'd0, flags});
    chk({tag, "_rd"}, {27'd0, busy_rd}, {27'd0, brd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall_in = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_is_div = 1'b0;
    issue_sel = 3'd0; issue_rd = 5'd0; issue_div_zero = 1'b0; wb_accept = 1'b0;
  endtask

  task automatic issue(input logic is_div, input logic [2:0] sel, input logic [4:0] rd,
                       input logic dz);
    issue_valid = 1'b1; issue_is_div = is_div; issue_sel = sel;
    issue_rd = rd; issue_div_zero = dz;
  endtask

  initial begin
    idle_inputs();
    Rst = 1'b0;
    #12;
    expect_st("reset", 6'b001000, 5'd0);
    chk("reset_sel", {29'd0, unit_sel}, 32'd0);
    chk("reset_isdiv_dz", {30'd0, res_is_div, res_dz}, 32'd0);
    Rst = 1'b1;

    // Mul, sel=0, rd=5: start +1, result +4 after start.
    tick(); issue(1'b0, 3'd0, 5'd5, 1'b0); #1;
    chk("mul_ready_at_issue", {31'd0, unit_ready}, 32'd1);
    tick(); idle_inputs(); #1;
    expect_st("mul_start", 6'b100010, 5'd5);
    for (int i = 2; i <= 4; i++) begin
      tick(); #1;
      expect_st("mul_wait", 6'b000010, 5'd5);
    end
    tick(); #1;
    expect_st("mul_done", 6'b000110, 5'd5);
    chk("mul_isdiv", {31'd0, res_is_div}, 32'd0);
    tick(); wb_accept = 1'b1; #1;
    expect_st("mul_accept", 6'b001110, 5'd5);
    tick(); wb_accept = 1'b0; #1;
    expect_st("mul_idle", 6'b001000, 5'd0);

    // Div, sel=5, rd=7: result 33 cycles after start, held 3 cycles.
    tick(); issue(1'b1, 3'd5, 5'd7, 1'b0); #1;
    tick(); idle_inputs(); #1;
    expect_st("div_start", 6'b010010, 5'd7);
    chk("div_sel", {29'd0, unit_sel}, 32'd5);
    for (int i = 2; i <= 33; i++) begin
      tick(); #1;
      expect_st("div_wait", 6'b000010, 5'd7);
    end
    for (int i = 0; i < 3; i++) begin
      tick(); #1;
      expect_st("div_hold", 6'b000110, 5'd7);
      chk("div_hold_isdiv_dz", {30'd0, res_is_div, res_dz}, 32'd2);
    end
    tick(); wb_accept = 1'b1; #1;
    expect_st("div_accept", 6'b001110, 5'd7);
    tick(); wb_accept = 1'b0; #1;
    expect_st("div_idle", 6'b001000, 5'd0);

    // Divide by zero: no strobe, result next cycle.
    tick(); issue(1'b1, 3'd4, 5'd9, 1'b1); #1;
    tick(); idle_inputs(); wb_accept = 1'b1; #1;
    expect_st("dz_done", 6'b001110, 5'd9);
    chk("dz_isdiv_dz", {30'd0, res_is_div, res_dz}, 32'd3);
    tick(); idle_inputs(); #1;
    expect_st("dz_idle", 6'b001000, 5'd0);

    // Flush in DONE overrides accept and a coincident issue; no kill.
    tick(); issue(1'b1, 3'd4, 5'd10, 1'b1); #1;
    tick(); idle_inputs(); issue(1'b0, 3'd1, 5'd11, 1'b0);
    wb_accept = 1'b1; flush = 1'b1; #1;
    tick(); idle_inputs(); #1;
    expect_st("flush_done", 6'b001000, 5'd0);

    // Flush coincident with issue from IDLE: nothing launches.
    tick(); issue(1'b0, 3'd1, 5'd11, 1'b0); flush = 1'b1; #1;
    tick(); idle_inputs(); #1;
    expect_st("flush_issue", 6'b001000, 5'd0);

    // Flush at cycle 10 of a div: one kill pulse, result never appears.
    tick(); issue(1'b1, 3'd5, 5'd12, 1'b0); #1;
    tick(); idle_inputs(); #1;
    for (int i = 2; i <= 9; i++) begin
      tick(); #1;
    end
    tick(); flush = 1'b1; #1;
    expect_st("div_flush_cyc", 6'b000010, 5'd12);
    tick(); flush = 1'b0; #1;
    expect_st("div_kill", 6'b001001, 5'd0);
    tick(); #1;
    expect_st("div_kill_end", 6'b001000, 5'd0);
    for (int i = 0; i < 30; i++) begin
      tick(); #1;
      chk("div_flushed_noresult", {31'd0, res_valid}, 32'd0);
    end

    // Back-to-back: accept + new mul issue in the same cycle.
    tick(); issue(1'b0, 3'd2, 5'd3, 1'b0); #1;
    tick(); idle_inputs(); #1;
    for (int i = 2; i <= 5; i++) begin
      tick(); #1;
    end
    expect_st("b2b_first_done", 6'b000110, 5'd3);
    issue(1'b0, 3'd6, 5'd4, 1'b0); wb_accept = 1'b1; #1;
    chk("b2b_ready", {31'd0, unit_ready}, 32'd1);
    tick(); idle_inputs(); #1;
    expect_st("b2b_second_start", 6'b100010, 5'd4);
    chk("b2b_sel", {29'd0, unit_sel}, 32'd6);
    tick(); wb_accept = 1'b1; #1;
    expect_st("b2b_stray_accept", 6'b000010, 5'd4);
    tick(); wb_accept = 1'b0; #1;
    tick(); #1;
    tick(); #1;
    expect_st("b2b_second_done", 6'b000110, 5'd4);
    tick(); wb_accept = 1'b1; #1;
    tick(); wb_accept = 1'b0; #1;
    expect_st("b2b_idle", 6'b001000, 5'd0);

    // Stall blocks issue from IDLE.
    tick(); issue(1'b0, 3'd1, 5'd6, 1'b0); stall_in = 1'b1; #1;
    tick(); idle_inputs(); #1;
    expect_st("stall_blocks_issue", 6'b001000, 5'd0);

    // Stall for 6 cycles during a mul: timing unchanged, result held.
    tick(); issue(1'b0, 3'd1, 5'd6, 1'b0); #1;
    tick(); idle_inputs(); stall_in = 1'b1; #1;
    expect_st("stall_mul_start", 6'b100010, 5'd6);
    for (int i = 2; i <= 4; i++) begin
      tick(); #1;
    end
    tick(); #1;
    expect_st("stall_mul_done", 6'b000110, 5'd6);
    tick(); #1;
    expect_st("stall_mul_hold", 6'b000110, 5'd6);
    tick(); stall_in = 1'b0; wb_accept = 1'b1; #1;
    tick(); wb_accept = 1'b0; #1;
    expect_st("stall_mul_idle", 6'b001000, 5'd0);

    // Async reset mid-div.
    tick(); issue(1'b1, 3'd3, 5'd8, 1'b0); #1;
    tick(); idle_inputs(); #1;
    for (int i = 0; i < 4; i++) begin
      tick(); #1;
    end
    expect_st("rst_pre", 6'b000010, 5'd8);
    #2; Rst = 1'b0; #1;
    expect_st("rst_async", 6'b001000, 5'd0);
    chk("rst_async_sel", {29'd0, unit_sel}, 32'd0);
    chk("rst_async_isdiv", {31'd0, res_is_div}, 32'd0);
    #2; Rst = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(); #1;
      chk("rst_no_result", {30'd0, res_valid, kill}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
